// File: rtl/fios_casc_ctrl.sv
// Control sequencer for the first PE of the cascaded FIOS Montgomery chain.
// Outputs are registered from the next-state decode so each one is valid in the same cycle as the state it describes.
module fios_casc_ctrl #(
  parameter int  WORD_COUNT    = 8,
  parameter int  DSP_REG_LEVEL = 3,
  localparam int ITER_W        = $clog2(WORD_COUNT)
) (
  input  logic              clock_i,
  input  logic              reset_n_i,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [ITER_W-1:0] iter_idx_o,
  output logic              a_word_rd_o,
  output logic              a_reg_en_o,
  output logic              m_reg_en_o,
  output logic [1:0]        mux_A_sel_o,
  output logic [1:0]        mux_B_sel_o,
  output logic [1:0]        mux_C_sel_o,
  output logic              CREG_en_o,
  output logic [8:0]        OPMODE_o,
  output logic              RES_delay_en_o
);

  localparam int                WAIT_W    = (DSP_REG_LEVEL > 1) ? $clog2(DSP_REG_LEVEL) : 1;
  localparam bit                HAS_WAIT  = (DSP_REG_LEVEL > 1);
  localparam logic [WAIT_W-1:0] WAIT_LOAD = HAS_WAIT ? WAIT_W'(DSP_REG_LEVEL - 2) : '0;
  localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(WORD_COUNT - 1);
  localparam logic [8:0]        OP_M      = 9'b000000101;
  localparam logic [8:0]        OP_MC     = 9'b000110101;

  // S_LSLOT is the spare cycle between LOAD and AB that makes an iteration 3L+4 cycles long
  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_LSLOT, S_AB, S_W_AB, S_MQ, S_W_MQ,
    S_CAPM, S_MP, S_W_MP, S_RESCAP, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ITER_W-1:0]   iter_q, iter_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                busy_d, done_d, a_word_rd_d, a_reg_en_d, m_reg_en_d;
  logic                creg_en_d, res_delay_en_d;
  logic [1:0]          mux_a_d, mux_b_d, mux_c_d;
  logic [8:0]          opmode_d;

  // Next-state sequencing plus decode of the outputs for the state being entered
  always_comb begin
    state_d        = state_q;
    iter_d         = iter_q;
    wait_d         = wait_q;
    busy_d         = 1'b0;
    done_d         = 1'b0;
    a_word_rd_d    = 1'b0;
    a_reg_en_d     = 1'b0;
    m_reg_en_d     = 1'b0;
    creg_en_d      = 1'b0;
    res_delay_en_d = 1'b0;
    mux_a_d        = 2'd0;
    mux_b_d        = 2'd0;
    mux_c_d        = 2'd0;
    opmode_d       = 9'h000;

    case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_LOAD;
        else         state_d = S_IDLE;
      end
      S_LOAD:  state_d = S_LSLOT;
      S_LSLOT: state_d = S_AB;
      S_AB: begin
        if (HAS_WAIT) begin
          state_d = S_W_AB;
          wait_d  = WAIT_LOAD;
        end else begin
          state_d = S_MQ;
        end
      end
      S_W_AB: begin
        if (wait_q == '0) state_d = S_MQ;
        else              wait_d  = wait_q - WAIT_W'(1);
      end
      S_MQ: begin
        if (HAS_WAIT) begin
          state_d = S_W_MQ;
          wait_d  = WAIT_LOAD;
        end else begin
          state_d = S_CAPM;
        end
      end
      S_W_MQ: begin
        if (wait_q == '0) state_d = S_CAPM;
        else              wait_d  = wait_q - WAIT_W'(1);
      end
      S_CAPM: state_d = S_MP;
      S_MP: begin
        if (HAS_WAIT) begin
          state_d = S_W_MP;
          wait_d  = WAIT_LOAD;
        end else begin
          state_d = S_RESCAP;
        end
      end
      S_W_MP: begin
        if (wait_q == '0) state_d = S_RESCAP;
        else              wait_d  = wait_q - WAIT_W'(1);
      end
      S_RESCAP: begin
        if (iter_q == ITER_LAST) begin
          state_d = S_DONE;
          iter_d  = '0;
        end else begin
          state_d = S_LOAD;
          iter_d  = iter_q + ITER_W'(1);
        end
      end
      S_DONE: begin
        iter_d = '0;
        if (start_i) state_d = S_LOAD;
        else         state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        iter_d  = '0;
        wait_d  = '0;
      end
    endcase

    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);

    case (state_d)
      S_LOAD: begin
        a_word_rd_d = 1'b1;
        a_reg_en_d  = 1'b1;
      end
      S_AB: begin
        if (iter_d == '0) begin
          opmode_d = OP_M;
        end else begin
          opmode_d  = OP_MC;
          mux_c_d   = 2'd1;
          creg_en_d = 1'b1;
        end
      end
      S_MQ: begin
        mux_a_d  = 2'd1;
        mux_b_d  = 2'd1;
        opmode_d = OP_M;
      end
      S_CAPM: m_reg_en_d = 1'b1;
      S_MP: begin
        mux_a_d   = 2'd2;
        mux_b_d   = 2'd2;
        mux_c_d   = 2'd2;
        opmode_d  = OP_MC;
        creg_en_d = 1'b1;
      end
      S_RESCAP: res_delay_en_d = 1'b1;
      S_DONE:   done_d         = 1'b1;
      default:  done_d         = 1'b0;
    endcase
  end

  // State, counters and registered outputs; reset overrides everything
  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      state_q        <= S_IDLE;
      iter_q         <= '0;
      wait_q         <= '0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
      a_word_rd_o    <= 1'b0;
      a_reg_en_o     <= 1'b0;
      m_reg_en_o     <= 1'b0;
      mux_A_sel_o    <= 2'd0;
      mux_B_sel_o    <= 2'd0;
      mux_C_sel_o    <= 2'd0;
      CREG_en_o      <= 1'b0;
      OPMODE_o       <= 9'h000;
      RES_delay_en_o <= 1'b0;
    end else begin
      state_q        <= state_d;
      iter_q         <= iter_d;
      wait_q         <= wait_d;
      busy_o         <= busy_d;
      done_o         <= done_d;
      a_word_rd_o    <= a_word_rd_d;
      a_reg_en_o     <= a_reg_en_d;
      m_reg_en_o     <= m_reg_en_d;
      mux_A_sel_o    <= mux_a_d;
      mux_B_sel_o    <= mux_b_d;
      mux_C_sel_o    <= mux_c_d;
      CREG_en_o      <= creg_en_d;
      OPMODE_o       <= opmode_d;
      RES_delay_en_o <= res_delay_en_d;
    end
  end

  assign iter_idx_o = iter_q;

endmodule

// File: tb/tb_fios_casc_ctrl.sv
// Directed bench for fios_casc_ctrl: three instances (L=3/WC=4, L=1/WC=2, L=3/WC=8)
// checked cycle by cycle against a timeline built from the iteration schedule.
module tb_fios_casc_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       rst_n_0, start_0, busy_0, done_0, ard_0, aen_0, men_0, creg_0, rde_0;
  logic [1:0] ma_0, mb_0, mc_0, it_0;
  logic [8:0] op_0;
  logic       rst_n_1, start_1, busy_1, done_1, ard_1, aen_1, men_1, creg_1, rde_1;
  logic [1:0] ma_1, mb_1, mc_1;
  logic [0:0] it_1;
  logic [8:0] op_1;
  logic       rst_n_2, start_2, busy_2, done_2, ard_2, aen_2, men_2, creg_2, rde_2;
  logic [1:0] ma_2, mb_2, mc_2;
  logic [2:0] it_2;
  logic [8:0] op_2;

  fios_casc_ctrl #(.WORD_COUNT(4), .DSP_REG_LEVEL(3)) dut0 (
    .clock_i(clk), .reset_n_i(rst_n_0), .start_i(start_0), .busy_o(busy_0), .done_o(done_0),
    .iter_idx_o(it_0), .a_word_rd_o(ard_0), .a_reg_en_o(aen_0), .m_reg_en_o(men_0),
    .mux_A_sel_o(ma_0), .mux_B_sel_o(mb_0), .mux_C_sel_o(mc_0), .CREG_en_o(creg_0),
    .OPMODE_o(op_0), .RES_delay_en_o(rde_0));

  fios_casc_ctrl #(.WORD_COUNT(2), .DSP_REG_LEVEL(1)) dut1 (
    .clock_i(clk), .reset_n_i(rst_n_1), .start_i(start_1), .busy_o(busy_1), .done_o(done_1),
    .iter_idx_o(it_1), .a_word_rd_o(ard_1), .a_reg_en_o(aen_1), .m_reg_en_o(men_1),
    .mux_A_sel_o(ma_1), .mux_B_sel_o(mb_1), .mux_C_sel_o(mc_1), .CREG_en_o(creg_1),
    .OPMODE_o(op_1), .RES_delay_en_o(rde_1));

  fios_casc_ctrl #(.WORD_COUNT(8), .DSP_REG_LEVEL(3)) dut2 (
    .clock_i(clk), .reset_n_i(rst_n_2), .start_i(start_2), .busy_o(busy_2), .done_o(done_2),
    .iter_idx_o(it_2), .a_word_rd_o(ard_2), .a_reg_en_o(aen_2), .m_reg_en_o(men_2),
    .mux_A_sel_o(ma_2), .mux_B_sel_o(mb_2), .mux_C_sel_o(mc_2), .CREG_en_o(creg_2),
    .OPMODE_o(op_2), .RES_delay_en_o(rde_2));

  // Packed observation: {2'b0, busy, done, ard, aen, men, creg, rde, mA, mB, mC, opmode, iter[7:0]}
  wire [31:0] obs_0 = {2'b00, busy_0, done_0, ard_0, aen_0, men_0, creg_0, rde_0,
                       ma_0, mb_0, mc_0, op_0, 6'd0, it_0};
  wire [31:0] obs_1 = {2'b00, busy_1, done_1, ard_1, aen_1, men_1, creg_1, rde_1,
                       ma_1, mb_1, mc_1, op_1, 7'd0, it_1};
  wire [31:0] obs_2 = {2'b00, busy_2, done_2, ard_2, aen_2, men_2, creg_2, rde_2,
                       ma_2, mb_2, mc_2, op_2, 5'd0, it_2};

  task automatic chk(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  // Expected outputs in cycle c after start is sampled at edge 0 (LOAD at cycle 1).
  // Iteration schedule: LOAD @0, AB @2, MQ @2+L, CAPM @2+2L, MP @3+2L, RESCAP @3+3L; length 3L+4.
  function automatic logic [31:0] exp_vec(input int L, input int wc, input int c);
    int len, it, ph;
    logic busy, done, ard, aen, men, creg, rde;
    logic [1:0] ma, mb, mc;
    logic [8:0] op;
    logic [7:0] iv;
    len = 3 * L + 4;
    busy = 1'b0; done = 1'b0; ard = 1'b0; aen = 1'b0; men = 1'b0; creg = 1'b0; rde = 1'b0;
    ma = 2'd0; mb = 2'd0; mc = 2'd0; op = 9'h000; iv = 8'd0;
    if (c >= 1 && c <= wc * len) begin
      it   = (c - 1) / len;
      ph   = (c - 1) % len;
      busy = 1'b1;
      iv   = 8'(it);
      if (ph == 0) begin
        ard = 1'b1; aen = 1'b1;
      end else if (ph == 2) begin
        if (it == 0) op = 9'h005;
        else begin op = 9'h035; mc = 2'd1; creg = 1'b1; end
      end else if (ph == 2 + L) begin
        ma = 2'd1; mb = 2'd1; op = 9'h005;
      end else if (ph == 2 + 2 * L) begin
        men = 1'b1;
      end else if (ph == 3 + 2 * L) begin
        ma = 2'd2; mb = 2'd2; mc = 2'd2; op = 9'h035; creg = 1'b1;
      end else if (ph == 3 + 3 * L) begin
        rde = 1'b1;
      end
    end else if (c == wc * len + 1) begin
      done = 1'b1;
    end
    return {2'b00, busy, done, ard, aen, men, creg, rde, ma, mb, mc, op, iv};
  endfunction

  int n_ard, n_men, n_rde, done_cyc, mono_bad, max_it, prev_it, n_done;

  initial begin
    rst_n_0 = 1'b0; rst_n_1 = 1'b0; rst_n_2 = 1'b0;
    start_0 = 1'b0; start_1 = 1'b0; start_2 = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_dut0", 0, obs_0, 32'h0);
    chk("reset_dut1", 0, obs_1, 32'h0);
    chk("reset_dut2", 0, obs_2, 32'h0);
    rst_n_0 = 1'b1; rst_n_1 = 1'b1; rst_n_2 = 1'b1;
    @(negedge clk);
    chk("idle_dut0", 0, obs_0, 32'h0);

    // L=3, WC=4: full timeline, done only at 53, then idle
    start_0 = 1'b1;
    for (int c = 1; c <= 56; c++) begin
      @(negedge clk);
      if (c == 1) start_0 = 1'b0;
      chk("l3_run", c, obs_0, exp_vec(3, 4, c));
    end

    // L=1, WC=2: no wait states, done at 15
    start_1 = 1'b1;
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      if (c == 1) start_1 = 1'b0;
      chk("l1_run", c, obs_1, exp_vec(1, 2, c));
    end

    // start held high: ignored mid-run, new LOAD right after DONE with iter 0
    @(negedge clk);
    start_0 = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c <= 53) chk("held_start", c, obs_0, exp_vec(3, 4, c));
      else         chk("b2b_restart", c, obs_0, exp_vec(3, 4, c - 53));
    end
    start_0 = 1'b0;
    rst_n_0 = 1'b0;
    @(negedge clk);
    chk("reset_midrun", 0, obs_0, 32'h0);
    rst_n_0 = 1'b1;
    @(negedge clk);

    // reset during W_MQ of iteration 2 (cycle 33), then no done, then nominal rerun
    start_0 = 1'b1;
    for (int c = 1; c <= 33; c++) begin
      @(negedge clk);
      if (c == 1) start_0 = 1'b0;
      chk("pre_abort", c, obs_0, exp_vec(3, 4, c));
    end
    rst_n_0 = 1'b0;
    @(negedge clk);
    chk("abort_zero", 34, obs_0, 32'h0);
    rst_n_0 = 1'b1;
    n_done = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done_0 === 1'b1 || busy_0 === 1'b1) n_done++;
    end
    chk("abort_no_done", 0, 32'(n_done), 32'd0);
    start_0 = 1'b1;
    for (int c = 1; c <= 55; c++) begin
      @(negedge clk);
      if (c == 1) start_0 = 1'b0;
      chk("post_abort", c, obs_0, exp_vec(3, 4, c));
    end

    // WC=8 event counts and iter_idx monotonicity; done expected at 8*13+1
    n_ard = 0; n_men = 0; n_rde = 0; done_cyc = -1; mono_bad = 0; max_it = 0; prev_it = 0;
    start_2 = 1'b1;
    for (int c = 1; c <= 120; c++) begin
      @(negedge clk);
      if (c == 1) start_2 = 1'b0;
      if (ard_2 === 1'b1) n_ard++;
      if (men_2 === 1'b1) n_men++;
      if (rde_2 === 1'b1) n_rde++;
      if (done_2 === 1'b1 && done_cyc < 0) done_cyc = c;
      if (busy_2 === 1'b1) begin
        if (int'(it_2) < prev_it) mono_bad++;
        prev_it = int'(it_2);
        if (int'(it_2) > max_it) max_it = int'(it_2);
      end
    end
    chk("cnt_a_word_rd", 0, 32'(n_ard), 32'd8);
    chk("cnt_m_reg_en", 0, 32'(n_men), 32'd8);
    chk("cnt_res_delay", 0, 32'(n_rde), 32'd8);
    chk("done_cycle_wc8", 0, 32'(done_cyc), 32'd105);
    chk("iter_monotonic", 0, 32'(mono_bad), 32'd0);
    chk("iter_max", 0, 32'(max_it), 32'd7);
    chk("wc8_idle_end", 0, obs_2, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
